separable_input_first_allocator: RTL and testbench

- Switch allocator for a 5-port VC NoC router.
- Stage 1 runs per input port: it picks one requesting VC.
- Stage 2 runs per output port: it picks one input among the stage-1 winners that target that output.
- The final grant is combinational from the current requests and registered round-robin priority state. It feeds switch traversal.

---
 rtl/separable_input_first_allocator_pkg.sv | 20 ++
 rtl/separable_input_first_allocator_arbiter.sv | 47 ++++
 rtl/separable_input_first_allocator.sv | 141 ++++++++++++++
 tb/tb_separable_input_first_allocator.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/separable_input_first_allocator_pkg.sv
// ---------------------------------------------------------------------------
// noc_params
//   Shared router parameters. PORT_NUM is a package constant rather than a
//   module parameter, so the port enum width and the port list stay consistent
//   across every block that imports it.
// ---------------------------------------------------------------------------
package noc_params;

   localparam int PORT_NUM = 5;
   localparam int PORT_W   = $clog2(PORT_NUM);

   typedef enum logic [PORT_W-1:0] {
      LOCAL = 0,
      NORTH = 1,
      SOUTH = 2,
      EAST  = 3,
      WEST  = 4
   } port_t;

endpackage

// File: rtl/separable_input_first_allocator_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter
//   Purely combinational round-robin arbiter. The search starts at ptr, which
//   has the highest priority, and wraps from N-1 back to 0. The caller owns the
//   pointer register, so this block only picks a winner.
//   Ports:
//     request   [N]  request vector
//     ptr       [PW] index of the highest-priority requester (must be < N)
//     grant     [N]  one-hot winner (all zero when there is no request)
//     grant_idx [PW] binary index of the winner (0 when there is no request)
// ---------------------------------------------------------------------------
module round_robin_arbiter #(
   parameter  int N  = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  request,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx
);

   logic          found;
   logic [PW:0]   sum;
   logic [PW-1:0] j;

   // The walk order is ptr, ptr+1, ... mod N. The extra sum bit keeps ptr+i
   // from overflowing before the wrap is applied.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      j         = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (PW+1)'(i);
         if (sum >= (PW+1)'(N))
            sum = sum - (PW+1)'(N);
         j = sum[PW-1:0];
         if (!found && request[j]) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = j;
         end
      end
   end

endmodule

// File: rtl/separable_input_first_allocator.sv
// ---------------------------------------------------------------------------
// separable_input_first_allocator
//   Switch allocator for a 5-port VC router. Stage 1 picks one VC per input.
//   Stage 2 picks one input per output among the stage-1 winners. The grant is
//   combinational from the requests and the registered round-robin pointers,
//   so it has zero latency.
//   Ports:
//     clk             clock; the pointers update on the rising edge
//     RSTn            async active-low reset; clears the pointers and forces
//                     the grant to zero while it is low
//     vc_request      [PORT_NUM][VC_NUM] request bits
//     vc_target_port  [PORT_NUM] x [VC_NUM] requested output port per VC
//     vc_grant_final  [PORT_NUM][VC_NUM] grant, at most one bit per input and
//                     at most one grant per output
//   Build option: SIFA_ASSERT_EN compiles in simulation-only assertions that
//   check the grant invariants and the pointer ranges.
// ---------------------------------------------------------------------------
module separable_input_first_allocator
   import noc_params::*;
#(
   parameter int VC_NUM = 2
) (
   input  logic                              clk,
   input  logic                              RSTn,
   input  logic [PORT_NUM-1:0][VC_NUM-1:0]   vc_request,
   input  port_t [VC_NUM-1:0]                vc_target_port [PORT_NUM],
   output logic [PORT_NUM-1:0][VC_NUM-1:0]   vc_grant_final
);

   localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

   // pointer state
   logic [PORT_NUM-1:0][VW-1:0]       in_ptr;
   logic [PORT_NUM-1:0][PORT_W-1:0]   out_ptr;

   // stage 1
   logic [PORT_NUM-1:0][VC_NUM-1:0]   s1_grant;
   logic [PORT_NUM-1:0][VW-1:0]       s1_idx;
   logic [PORT_NUM-1:0]               s1_vld;
   logic [PORT_NUM-1:0][PORT_W-1:0]   s1_target;

   // stage 2, indexed [output][input]
   logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_req;
   logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_grant;
   logic [PORT_NUM-1:0][PORT_W-1:0]   s2_idx;

   // next pointer values, used only when a grant is issued
   logic [PORT_NUM-1:0][VW-1:0]       in_ptr_nxt;
   logic [PORT_NUM-1:0][PORT_W-1:0]   out_ptr_nxt;

   // ---- stage 1: one VC per input -----------------------------------------
   for (genvar p = 0; p < PORT_NUM; p++) begin : g_s1
      round_robin_arbiter #(.N(VC_NUM)) u_vc_arb (
         .request   (vc_request[p]),
         .ptr       (in_ptr[p]),
         .grant     (s1_grant[p]),
         .grant_idx (s1_idx[p])
      );

      assign s1_vld[p]    = |s1_grant[p];
      assign s1_target[p] = vc_target_port[p][s1_idx[p]];

      assign in_ptr_nxt[p] = (s1_idx[p] == VW'(VC_NUM-1)) ? '0 : s1_idx[p] + 1'b1;
   end

   // ---- stage 2: one input per output -------------------------------------
   for (genvar o = 0; o < PORT_NUM; o++) begin : g_s2
      for (genvar i = 0; i < PORT_NUM; i++) begin : g_req
         assign s2_req[o][i] = s1_vld[i] && (s1_target[i] == PORT_W'(o));
      end

      round_robin_arbiter #(.N(PORT_NUM)) u_port_arb (
         .request   (s2_req[o]),
         .ptr       (out_ptr[o]),
         .grant     (s2_grant[o]),
         .grant_idx (s2_idx[o])
      );

      assign out_ptr_nxt[o] = (s2_idx[o] == PORT_W'(PORT_NUM-1)) ? '0 : s2_idx[o] + 1'b1;
   end

   // ---- final grant --------------------------------------------------------
   // An input is granted only if its stage-1 winner also won stage 2 at the
   // output it targets. RSTn gates the grant directly, so the grant drops
   // during reset without waiting for a clock edge.
   for (genvar p = 0; p < PORT_NUM; p++) begin : g_fin
      assign vc_grant_final[p] = (RSTn && s2_grant[s1_target[p]][p]) ? s1_grant[p] : '0;
   end

   // ---- pointer update ----------------------------------------------------
   // in_ptr moves only on a final grant. A stage-1 winner that loses stage 2
   // keeps its priority for the next cycle. Any stage-2 grant is also a final
   // grant, so out_ptr follows s2_grant directly.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         in_ptr  <= '0;
         out_ptr <= '0;
      end else begin
         for (int p = 0; p < PORT_NUM; p++)
            if (|vc_grant_final[p])
               in_ptr[p] <= in_ptr_nxt[p];
         for (int o = 0; o < PORT_NUM; o++)
            if (|s2_grant[o])
               out_ptr[o] <= out_ptr_nxt[o];
      end
   end

`ifdef SIFA_ASSERT_EN
   // Final grants regrouped per output, used only by the checks below.
   logic [PORT_NUM-1:0][PORT_NUM-1:0] fin_by_out;
   always_comb begin
      fin_by_out = '0;
      for (int p = 0; p < PORT_NUM; p++)
         if (|vc_grant_final[p])
            fin_by_out[s1_target[p]][p] = 1'b1;
   end

   a_subset: assert property (@(posedge clk) disable iff (!RSTn)
      (vc_grant_final & ~vc_request) == '0)
      else $error("grant outside request");

   for (genvar p = 0; p < PORT_NUM; p++) begin : g_a_in
      a_in_onehot: assert property (@(posedge clk) disable iff (!RSTn)
         $onehot0(vc_grant_final[p]))
         else $error("input %0d has more than one grant", p);
      a_in_ptr: assert property (@(posedge clk) disable iff (!RSTn)
         int'(in_ptr[p]) < VC_NUM)
         else $error("in_ptr[%0d] out of range", p);
   end

   for (genvar o = 0; o < PORT_NUM; o++) begin : g_a_out
      a_out_onehot: assert property (@(posedge clk) disable iff (!RSTn)
         $onehot0(fin_by_out[o]))
         else $error("output %0d serves more than one grant", o);
      a_out_ptr: assert property (@(posedge clk) disable iff (!RSTn)
         int'(out_ptr[o]) < PORT_NUM)
         else $error("out_ptr[%0d] out of range", o);
   end
`endif

endmodule

// File: tb/tb_separable_input_first_allocator.sv
// ---------------------------------------------------------------------------
// tb_separable_input_first_allocator
//   The stimulus pushes the expected grant for each cycle into a queue. The
//   expected value is a hand-derived constant for the directed cases and a
//   reference-model result for the random cases. A monitor on the falling edge
//   pops each entry and compares it with the DUT. On every cycle the monitor
//   also checks the grant invariants directly.
// ---------------------------------------------------------------------------
module tb_separable_input_first_allocator;
   import noc_params::*;

   localparam int VC = 2;
   typedef logic [PORT_NUM-1:0][VC-1:0] gvec_t;

   logic   clk;
   logic   rst_n;
   gvec_t  req;
   port_t [VC-1:0] tgt [PORT_NUM];
   gvec_t  gnt;

   separable_input_first_allocator #(.VC_NUM(VC)) dut (
      .clk            (clk),
      .RSTn           (rst_n),
      .vc_request     (req),
      .vc_target_port (tgt),
      .vc_grant_final (gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   gvec_t exp_q[$];
   string name_q[$];

   // reference model state: the priority position at each input and output
   int in_p  [PORT_NUM];
   int out_p [PORT_NUM];

   // Each input nominates the first requesting VC at or after its pointer.
   // Each output takes the first nominating input at or after its pointer.
   function automatic gvec_t model_grant();
      gvec_t g;
      int    win [PORT_NUM];
      bit    done;
      g = '0;
      if (!rst_n) return g;
      for (int p = 0; p < PORT_NUM; p++) begin
         win[p] = -1;
         for (int k = 0; k < VC; k++) begin
            int v;
            v = (in_p[p] + k) % VC;
            if (win[p] < 0 && req[p][v]) win[p] = v;
         end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
         done = 0;
         for (int k = 0; k < PORT_NUM; k++) begin
            int i;
            i = (out_p[o] + k) % PORT_NUM;
            if (!done && win[i] >= 0 && int'(tgt[i][win[i]]) == o) begin
               g[i][win[i]] = 1'b1;
               done = 1;
            end
         end
      end
      return g;
   endfunction

   // Apply one cycle: queue the expected grant, cross the clock edge, then
   // advance the model pointers from the model's own grant.
   task automatic run_cycle(input string nm, input bit use_const, input gvec_t cexp);
      gvec_t m;
      m = model_grant();
      exp_q.push_back(use_const ? cexp : m);
      name_q.push_back(nm);
      @(posedge clk);
      if (!rst_n) begin
         for (int p = 0; p < PORT_NUM; p++) begin in_p[p] = 0; out_p[p] = 0; end
      end else begin
         for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC; v++)
               if (m[p][v]) begin
                  in_p[p] = (v + 1) % VC;
                  out_p[int'(tgt[p][v])] = (p + 1) % PORT_NUM;
               end
      end
      #1;
   endtask

   task automatic clear_in();
      req = '0;
      for (int p = 0; p < PORT_NUM; p++)
         for (int v = 0; v < VC; v++) tgt[p][v] = LOCAL;
   endtask

   task automatic rand_in();
      req = gvec_t'($urandom);
      case ($urandom_range(0, 3))
         0: req = req & gvec_t'($urandom);
         1: begin req = '0; req[$urandom_range(0, PORT_NUM-1)][$urandom_range(0, VC-1)] = 1'b1; end
         default: ;
      endcase
      for (int p = 0; p < PORT_NUM; p++)
         for (int v = 0; v < VC; v++) tgt[p][v] = port_t'($urandom_range(0, PORT_NUM-1));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rand_in();
      run_cycle("reset0", 1, '0);
      rand_in();
      run_cycle("reset1", 1, '0);
      rst_n = 1'b1;
      clear_in();
   endtask

   // ---- monitor ------------------------------------------------------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         gvec_t e;
         string nm;
         int    cnt [PORT_NUM];
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         checks++;
         if (gnt !== e) begin
            errors++;
            $display("FAIL %s: grant got %h expected %h", nm, gnt, e);
         end
         checks++;
         if ((gnt & ~req) != '0) begin
            errors++;
            $display("FAIL %s subset: grant %h request %h", nm, gnt, req);
         end
         for (int o = 0; o < PORT_NUM; o++) cnt[o] = 0;
         for (int p = 0; p < PORT_NUM; p++) begin
            checks++;
            if (!$onehot0(gnt[p])) begin
               errors++;
               $display("FAIL %s in%0d: grant %b expected onehot0", nm, p, gnt[p]);
            end
            for (int v = 0; v < VC; v++)
               if (gnt[p][v] === 1'b1) cnt[int'(tgt[p][v])]++;
         end
         for (int o = 0; o < PORT_NUM; o++) begin
            checks++;
            if (cnt[o] > 1) begin
               errors++;
               $display("FAIL %s out%0d: %0d grants expected <=1", nm, o, cnt[o]);
            end
         end
      end
   end

   // ---- stimulus -----------------------------------------------------------
   initial begin
      gvec_t c;
      for (int p = 0; p < PORT_NUM; p++) begin in_p[p] = 0; out_p[p] = 0; end
      rst_n = 1'b0;
      clear_in();
      @(posedge clk);
      #1;

      // reset holds the grant at zero even with requests present
      do_reset();

      // lone request: [2][1] to EAST
      req[2][1] = 1'b1; tgt[2][1] = EAST;
      c = '0; c[2][1] = 1'b1;
      run_cycle("single", 1, c);

      // two VCs on one input: VC0 first, then the pointer moves to VC1
      do_reset();
      req[1][0] = 1'b1; tgt[1][0] = NORTH;
      req[1][1] = 1'b1; tgt[1][1] = SOUTH;
      c = '0; c[1][0] = 1'b1;
      run_cycle("same_in_a", 1, c);
      c = '0; c[1][1] = 1'b1;
      run_cycle("same_in_b", 1, c);

      // output conflict on WEST: input 0 first, then input 3
      do_reset();
      req[0][0] = 1'b1; tgt[0][0] = WEST;
      req[3][0] = 1'b1; tgt[3][0] = WEST;
      c = '0; c[0][0] = 1'b1;
      run_cycle("conflict_a", 1, c);
      c = '0; c[3][0] = 1'b1;
      run_cycle("conflict_b", 1, c);

      // disjoint outputs are granted together
      clear_in();
      req[0][0] = 1'b1; tgt[0][0] = NORTH;
      req[4][1] = 1'b1; tgt[4][1] = EAST;
      c = '0; c[0][0] = 1'b1; c[4][1] = 1'b1;
      run_cycle("disjoint", 1, c);

      // all inputs target LOCAL from VC1: input 0 wins first, then the
      // output pointer wraps around the inputs
      do_reset();
      for (int p = 0; p < PORT_NUM; p++) begin req[p][1] = 1'b1; tgt[p][1] = LOCAL; end
      for (int k = 0; k < PORT_NUM + 1; k++) begin
         c = '0; c[k % PORT_NUM][1] = 1'b1;
         run_cycle("wrap", 1, c);
      end

      // random traffic with occasional mid-run reset, checked against the model
      do_reset();
      for (int k = 0; k < 200; k++) begin
         rst_n = ($urandom_range(0, 24) != 0);
         rand_in();
         run_cycle("random", 0, '0);
      end
      rst_n = 1'b1;
      clear_in();

      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
